// File: rtl/hpdl_refresh_ctrl_pkg.sv
// hpdl_pkg: shared constants, refresh FSM state type and character helpers
// for the HPDL-1414 refresh controller.
package hpdl_pkg;
  localparam logic [7:0] CH_BKSP  = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CARET = 8'h5F;
  localparam int         DISPLAY_LEN = 16;

  typedef enum logic [1:0] {
    ST_SETUP  = 2'd0,
    ST_STROBE = 2'd1,
    ST_HOLD   = 2'd2
  } refresh_state_e;

  // The display only has glyphs for 0x20..0x5F.
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h5F);
  endfunction

  // Lowercase letters map onto the uppercase glyphs.
  function automatic logic [7:0] fold_case(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) ? c - 8'h20 : c;
  endfunction
endpackage

// File: rtl/hpdl_refresh_ctrl_if.sv
// Host-side character interface of the refresh controller.
//   i_char_valid/i_char_data/o_char_ready : character handshake
//   i_clear    : one-cycle blank request
//   i_caret_en : caret blink enable
//   o_cursor   : current cursor position
interface hpdl_refresh_ctrl_if;
  logic       i_char_valid;
  logic [7:0] i_char_data;
  logic       o_char_ready;
  logic       i_clear;
  logic       i_caret_en;
  logic [3:0] o_cursor;

  modport master (output i_char_valid, i_char_data, i_clear, i_caret_en,
                  input  o_char_ready, o_cursor);
  modport slave  (input  i_char_valid, i_char_data, i_clear, i_caret_en,
                  output o_char_ready, o_cursor);
endinterface

// File: rtl/hpdl_char_buffer.sv
// 16 x 7 character store: one synchronous write port, one asynchronous read
// port, every entry resets to space.
//   clk/rst            : clock, async active-high reset
//   we/waddr/wdata     : write port
//   raddr/rdata        : combinational read port
module hpdl_char_buffer
  import hpdl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [6:0] wdata,
  input  logic [3:0] raddr,
  output logic [6:0] rdata
);
  logic [DISPLAY_LEN-1:0][6:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     mem <= {DISPLAY_LEN{CH_SPACE[6:0]}};
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/hpdl_refresh_ctrl.sv
// Drives four HPDL-1414 4-digit displays from a 16-character buffer that a
// host fills through a terminal-like character stream (backspace, CR,
// form-feed clear, cursor with blinking caret).
//   CLK_i/RST_i : clock, async active-high reset
//   host        : character handshake, clear, caret enable, cursor
//   HPDL_D/A    : character code / digit address, stable SETUP..HOLD
//   HPDL_WR     : active-low write strobe per 4-digit device
module hpdl_refresh_ctrl
  import hpdl_pkg::*;
#(
  parameter int SETUP_CYC  = 4,
  parameter int PULSE_CYC  = 8,
  parameter int HOLD_CYC   = 4,
  parameter int BLINK_BITS = 23
) (
  input  logic                 CLK_i,
  input  logic                 RST_i,
  hpdl_refresh_ctrl_if.slave   host,
  output logic [6:0]           HPDL_D,
  output logic [1:0]           HPDL_A,
  output logic [3:0]           HPDL_WR
);
  localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAX_CYC + 1);

  // ---------------- host side ----------------
  logic       clearing, start_clr, accept, we;
  logic [3:0] clr_idx, cursor, cursor_nxt, waddr;
  logic [6:0] wdata, rd_data;
  logic [7:0] code;

  assign host.o_char_ready = !RST_i && !clearing && !host.i_clear;
  assign accept            = host.i_char_valid && host.o_char_ready;
  assign code              = fold_case(host.i_char_data);
  assign host.o_cursor     = cursor;

  always_comb begin
    we         = 1'b0;
    waddr      = cursor;
    wdata      = CH_SPACE[6:0];
    cursor_nxt = cursor;
    start_clr  = 1'b0;
    if (clearing) begin
      we    = 1'b1;
      waddr = clr_idx;
    end else if (host.i_clear) begin
      start_clr = 1'b1;
    end else if (accept) begin
      if (is_printable(code)) begin
        we    = 1'b1;
        wdata = code[6:0];
        // last cell keeps being overwritten once the line is full
        if (cursor != 4'hF) cursor_nxt = cursor + 4'd1;
      end else begin
        case (code)
          CH_BKSP: if (cursor != 4'd0) begin
            cursor_nxt = cursor - 4'd1;
            we         = 1'b1;
            waddr      = cursor - 4'd1;
          end
          CH_CR:   cursor_nxt = 4'd0;
          CH_FF:   start_clr  = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      clearing <= 1'b0;
      clr_idx  <= 4'd0;
      cursor   <= 4'd0;
    end else if (start_clr) begin
      clearing <= 1'b1;
      clr_idx  <= 4'd0;
      cursor   <= 4'd0;
    end else if (clearing) begin
      clr_idx <= clr_idx + 4'd1;
      if (clr_idx == 4'hF) clearing <= 1'b0;
    end else begin
      cursor <= cursor_nxt;
    end
  end

  // ---------------- refresh side ----------------
  refresh_state_e        state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [3:0]            p, p_nxt;
  logic                  last, load;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic [3:0]            wr_nxt;

  hpdl_char_buffer u_buf (
    .clk   (CLK_i),
    .rst   (RST_i),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (p_nxt),
    .rdata (rd_data)
  );

  always_comb begin
    state_nxt = state;
    last      = 1'b0;
    case (state)
      ST_SETUP:  begin
        last = (cnt == CW'(SETUP_CYC - 1));
        if (last) state_nxt = ST_STROBE;
      end
      ST_STROBE: begin
        last = (cnt == CW'(PULSE_CYC - 1));
        if (last) state_nxt = ST_HOLD;
      end
      ST_HOLD:   begin
        last = (cnt == CW'(HOLD_CYC - 1));
        if (last) state_nxt = ST_SETUP;
      end
      default:   state_nxt = ST_SETUP;
    endcase
    // p only moves on HOLD exit, so it is stable for the whole strobe
    wr_nxt = 4'hF;
    if (state_nxt == ST_STROBE) wr_nxt[p[3:2]] = 1'b0;
  end

  assign load  = (state == ST_HOLD) && last;
  assign p_nxt = p + 4'd1;

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state <= ST_SETUP;
      cnt   <= '0;
      p     <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= last ? '0 : cnt + CW'(1);
      if (load) p <= p_nxt;
    end
  end

  // Address/data are latched once per visit, so host writes to the cell
  // being shown only appear on its next visit.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      blink_cnt <= '0;
      HPDL_A    <= 2'b11;
      HPDL_D    <= CH_SPACE[6:0];
      HPDL_WR   <= 4'hF;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      HPDL_WR   <= wr_nxt;
      if (load) begin
        HPDL_A <= ~p_nxt[1:0];
        HPDL_D <= (host.i_caret_en && blink_cnt[BLINK_BITS-1] && (p_nxt == cursor)) ?
                  CH_CARET[6:0] : rd_data;
      end
    end
  end
endmodule

// File: tb/tb_hpdl_refresh_ctrl.sv
// Scoreboard bench for hpdl_refresh_ctrl: the driver queues expected cursor
// values per character and expected strobe contents per display cell; one
// monitor pops and compares on accepted handshakes and on completed strobes.
module tb_hpdl_refresh_ctrl;
  localparam int PULSE = 8;

  typedef struct { logic [3:0] cur; string nm; } cur_t;
  typedef struct { logic [3:0] p; logic [6:0] d; bit strict; string nm; } strb_t;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] d;
  logic [1:0] a;
  logic [3:0] wr;
  int unsigned cyc;
  int tests = 0;
  int fails = 0;

  cur_t  cur_q[$];
  strb_t exp_s[$];

  hpdl_refresh_ctrl_if hif();

  hpdl_refresh_ctrl #(.SETUP_CYC(4), .PULSE_CYC(PULSE), .HOLD_CYC(4), .BLINK_BITS(10)) dut (
    .CLK_i   (clk),
    .RST_i   (rst),
    .host    (hif),
    .HPDL_D  (d),
    .HPDL_A  (a),
    .HPDL_WR (wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- monitor ----------------
  bit         pend = 0, in_pulse = 0, elig = 0;
  int         len;
  logic [3:0] p_cap, wr_cap, want_wr;
  logic [6:0] d_cap;
  cur_t       ce;
  strb_t      se;

  function automatic logic [1:0] dev_of(input logic [3:0] w);
    case (w)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (pend) begin
      tests++;
      if (cur_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_accept: cursor=%0d, no character should be accepted", hif.o_cursor);
      end else begin
        ce = cur_q.pop_front();
        if (hif.o_cursor !== ce.cur) begin
          fails++;
          $display("FAIL %s cursor: got %0d want %0d", ce.nm, hif.o_cursor, ce.cur);
        end
      end
    end
    pend = !rst && hif.i_char_valid && hif.o_char_ready;

    if (wr != 4'hF) begin
      if (!in_pulse) begin
        in_pulse = 1; len = 1; elig = (exp_s.size() > 0);
        d_cap = d; wr_cap = wr; p_cap = {dev_of(wr), ~a};
      end else len++;
    end else if (in_pulse) begin
      in_pulse = 0;
      if (elig && exp_s.size() > 0 && (exp_s[0].p == p_cap || exp_s[0].strict)) begin
        se = exp_s.pop_front();
        want_wr = 4'hF;
        want_wr[se.p[3:2]] = 1'b0;
        tests++;
        if (p_cap !== se.p || d_cap !== se.d || wr_cap !== want_wr || len != PULSE) begin
          fails++;
          $display("FAIL %s strobe: p=%0d d=%h wr=%b len=%0d, want p=%0d d=%h wr=%b len=%0d",
                   se.nm, p_cap, d_cap, wr_cap, len, se.p, se.d, want_wr, PULSE);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [3:0] cur, input string nm);
    @(posedge clk); #1;
    hif.i_char_valid = 1'b1;
    hif.i_char_data  = c;
    cur_q.push_back('{cur, nm});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    hif.i_char_valid = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  task automatic expect_strobe(input logic [3:0] p, input logic [6:0] dv, input bit strict, input string nm);
    exp_s.push_back('{p, dv, strict, nm});
  endtask

  task automatic wait_strobes(input string nm);
    int n = 0;
    while (exp_s.size() > 0 && n < 700) begin @(negedge clk); n++; end
    if (exp_s.size() > 0) begin
      tests++; fails++;
      $display("FAIL %s timeout: %0d strobes still pending, want 0", nm, exp_s.size());
      exp_s.delete();
    end
  endtask

  task automatic wait_phase(input int unsigned target);
    int n = 0;
    while ((cyc % 1024) != target && n < 1100) begin @(negedge clk); n++; end
    chk("blink_align", cyc % 1024, target);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, n;
    rst = 1'b1;
    hif.i_char_valid = 0; hif.i_char_data = 0; hif.i_clear = 0; hif.i_caret_en = 0;
    repeat (3) @(negedge clk);
    chk("rst_wr", wr, 4'hF);
    chk("rst_a", a, 2'b11);
    chk("rst_d", d, 7'h20);
    chk("rst_ready", hif.o_char_ready, 1'b0);
    chk("rst_cursor", hif.o_cursor, 4'd0);
    @(posedge clk); #1 rst = 1'b0;

    // "ABC" back to back
    send(8'h41, 4'd1, "abc_A"); send(8'h42, 4'd2, "abc_B"); send(8'h43, 4'd3, "abc_C");
    idle();
    expect_strobe(4'd0, 7'h41, 0, "abc_p0");
    expect_strobe(4'd1, 7'h42, 0, "abc_p1");
    expect_strobe(4'd2, 7'h43, 0, "abc_p2");
    wait_strobes("abc");

    // 17 x 'Z': cursor saturates at 15
    for (int i = 0; i < 17; i++)
      send(8'h5A, (i < 12) ? 4'(4 + i) : 4'd15, "sat_Z");
    idle();
    expect_strobe(4'd2, 7'h43, 0, "sat_p2");
    expect_strobe(4'd14, 7'h5A, 0, "sat_p14");
    expect_strobe(4'd15, 7'h5A, 0, "sat_p15");
    wait_strobes("sat");

    // i_clear with a character presented: not accepted, 16-cycle blank
    @(posedge clk); #1;
    hif.i_char_valid = 1'b1; hif.i_char_data = 8'h51; hif.i_clear = 1'b1;
    @(negedge clk);
    chk("clr_ready_req", hif.o_char_ready, 1'b0);
    @(posedge clk); #1;
    hif.i_char_valid = 1'b0; hif.i_clear = 1'b0;
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!hif.o_char_ready) lows++;
    end
    chk("clr_ready_low_cycles", lows, 16);
    @(negedge clk);
    chk("clr_ready_back", hif.o_char_ready, 1'b1);
    chk("clr_cursor", hif.o_cursor, 4'd0);
    expect_strobe(4'd0, 7'h20, 0, "clr_p0");
    expect_strobe(4'd2, 7'h20, 0, "clr_p2");
    expect_strobe(4'd15, 7'h20, 0, "clr_p15");
    wait_strobes("clr");

    // backspace, CR, backspace at 0, unknown code
    send(8'h41, 4'd1, "bs_A"); send(8'h42, 4'd2, "bs_B"); send(8'h08, 4'd1, "bs_bksp");
    send(8'h0D, 4'd0, "bs_cr"); send(8'h08, 4'd0, "bs_bksp0"); send(8'h7F, 4'd0, "bs_other");
    idle();
    expect_strobe(4'd0, 7'h41, 0, "bs_p0");
    expect_strobe(4'd1, 7'h20, 0, "bs_p1");
    wait_strobes("bs");

    // form feed clears, then lowercase folds
    send(8'h0C, 4'd0, "ff");
    idle();
    send(8'h61, 4'd1, "lc_a");
    idle();
    expect_strobe(4'd0, 7'h41, 0, "lc_p0");
    expect_strobe(4'd1, 7'h20, 0, "ff_p1");
    wait_strobes("lc");

    // caret at cursor 1: shown in blink phase 1, buffer in phase 0
    hif.i_caret_en = 1'b1;
    wait_phase(520);
    expect_strobe(4'd1, 7'h5F, 0, "caret_on");
    wait_strobes("caret_on");
    wait_phase(8);
    expect_strobe(4'd1, 7'h20, 0, "caret_off");
    wait_strobes("caret_off");
    hif.i_caret_en = 1'b0;

    // reset in the middle of a strobe
    n = 0;
    while (wr == 4'hF && n < 100) begin @(negedge clk); n++; end
    chk("pre_rst_strobe_seen", (wr != 4'hF), 1'b1);
    #2 rst = 1'b1;
    #1 chk("rst_async_wr", wr, 4'hF);
    chk("rst_async_cursor", hif.o_cursor, 4'd0);
    @(posedge clk); #1 rst = 1'b0;
    expect_strobe(4'd0, 7'h20, 1, "post_rst_first");
    wait_strobes("post_rst");

    chk("cursor_queue_drained", cur_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hpdl_refresh_ctrl.md
HPDL_REFRESH_CTRL -- requirements
Module: hpdl_refresh_ctrl

Interface
REQ-001 The block SHALL have parameter SETUP_CYC, default 4, clock cycles that address/data are stable before the WR strobe.
REQ-002 The block SHALL have parameter PULSE_CYC, default 8, clock cycles that the WR strobe is held low.
REQ-003 The block SHALL have parameter HOLD_CYC, default 4, clock cycles that address/data are held after WR rises.
REQ-004 The block SHALL have parameter BLINK_BITS, default 23, the caret blink counter width; blink phase = counter MSB.
REQ-005 The block SHALL have port CLK_i, input, 1, single system clock; all logic on its rising edge.
REQ-006 The block SHALL have port RST_i, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port i_char_valid, input, 1, host character request.
REQ-008 The block SHALL have port i_char_data, input, 8, host character code.
REQ-009 The block SHALL have port o_char_ready, output, 1, character accepted when valid and ready are both high.
REQ-010 The block SHALL have port i_clear, input, 1, single-cycle request to blank the display.
REQ-011 The block SHALL have port i_caret_en, input, 1, enables caret blinking.
REQ-012 The block SHALL have port o_cursor, output, 4, current cursor position 0..15.
REQ-013 The block SHALL have ports HPDL_D, output, 7 (character code); HPDL_A, output, 2 (digit address); and HPDL_WR, output, 4 (active-low write strobes, one per 4-digit device).

Function
REQ-014 Refresh FSM states: SETUP -> STROBE -> HOLD -> SETUP; each state lasts SETUP_CYC, PULSE_CYC or HOLD_CYC cycles, and the refresh position p (4-bit) increments, wrapping 15 -> 0, on HOLD exit.
REQ-015 On SETUP entry: HPDL_A = ~p[1:0]; HPDL_D = buffer[p], or 0x5F when i_caret_en, blink phase = 1 and p == o_cursor; both held constant through HOLD.
REQ-016 In STROBE only, HPDL_WR[p[3:2]] = 0; all other strobes stay 1, and every strobe is 1 in SETUP and HOLD.
REQ-017 An accepted printable code 0x20..0x5F SHALL be written to buffer[cursor], then cursor = min(cursor+1, 15); at cursor 15 position 15 is overwritten.
REQ-018 Codes 0x61..0x7A SHALL be folded to uppercase (minus 0x20) and then handled as printable.
REQ-019 Code 0x08 (backspace): if cursor > 0, cursor decrements and 0x20 is written at the new cursor; at cursor 0, no effect.
REQ-020 Code 0x0D SHALL set cursor to 0 without a buffer write; code 0x0C SHALL start a clear, as if i_clear were asserted.
REQ-021 All other codes SHALL be accepted and have no effect.
REQ-022 Clear: 16 consecutive cycles write 0x20 to positions 0..15, and cursor = 0; o_char_ready = 0 during the clear; i_clear during a clear is ignored.
REQ-023 o_char_ready = !clearing && !i_clear; i_clear has priority, so a character presented in an i_clear cycle is not accepted.
REQ-024 Each accepted character SHALL complete in one cycle; sustained back-to-back acceptance is required.
REQ-025 A buffer write to position p during SETUP/STROBE/HOLD of p SHALL not change HPDL_D; it appears on p's next visit.
REQ-026 The refresh FSM SHALL run independently of host activity and clears; it never stalls.

Reset
REQ-027 While RST_i = 1: buffer all 0x20, cursor 0, p 0, FSM in SETUP with counter 0, blink counter 0, HPDL_WR = 4'b1111, HPDL_A = 2'b11, HPDL_D = 0x20, o_char_ready = 0.
REQ-028 Reset asserted mid-strobe SHALL drive HPDL_WR to 1 immediately (asynchronously); after reset release, the first strobe is for p = 0.

Structure
REQ-029 Shared package hpdl_pkg SHALL hold CH_BKSP 0x08, CH_FF 0x0C, CH_CR 0x0D, CH_SPACE 0x20, CH_CARET 0x5F, DISPLAY_LEN 16 and the refresh state enum.
REQ-030 Sub-module hpdl_char_buffer SHALL implement the 16x7 register file with one synchronous write port and one asynchronous read port, and with asynchronous reset to 0x20.

Verification
REQ-031 After reset, send "ABC" -> buffer[0..2] = 0x41,0x42,0x43, o_cursor = 3, and a WR[0] low pulse of 8 cycles occurs with A = 2'b11, D = 0x41.
REQ-032 Send 17 x 0x5A -> o_cursor saturates at 15, and position 15 = 0x5A.
REQ-033 Send "AB", 0x08 -> o_cursor = 1, buffer[1] = 0x20; then at cursor 0, 0x08 -> no change.
REQ-034 Assert i_clear together with i_char_valid = 1 -> char not accepted, o_char_ready low for 16 cycles, all positions 0x20, o_cursor 0.
REQ-035 Send 0x61 -> buffer[0] = 0x41; with i_caret_en = 1 and blink phase 1, the position-1 strobe carries D = 0x5F.
REQ-036 Assert RST_i during STROBE -> HPDL_WR = 4'b1111 in the same cycle, and the first post-reset strobe is at p = 0.
